// File: rtl/adc_meas_sched.sv
// Round-robin scheduler that time-shares one adc_read converter among NUM_CH channels:
// it captures request pulses, settles the mux, starts a conversion and returns a tagged result.
module adc_meas_sched #(
    parameter int NUM_CH         = 4,
    parameter int CH_WIDTH       = 2,
    parameter int DATA_WIDTH     = 24,
    parameter int DIAP_WIDTH     = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_WIDTH  = 20,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_CH-1:0]     req,
    output logic                  busy,
    output logic [NUM_CH-1:0]     pending,
    output logic [CH_WIDTH-1:0]   conv_mux_sel,
    output logic                  conv_start,
    input  logic                  conv_complete,
    input  logic [DATA_WIDTH-1:0] conv_data_1,
    input  logic [DATA_WIDTH-1:0] conv_data_2,
    input  logic [DIAP_WIDTH-1:0] conv_diap,
    output logic                  rsp_valid,
    output logic [CH_WIDTH-1:0]   rsp_ch,
    output logic [DATA_WIDTH-1:0] rsp_data_1,
    output logic [DATA_WIDTH-1:0] rsp_data_2,
    output logic [DIAP_WIDTH-1:0] rsp_diap,
    output logic                  rsp_timeout
);

    localparam int SETTLE_WIDTH = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    localparam logic [SETTLE_WIDTH-1:0]  SETTLE_LAST  = SETTLE_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CH_WIDTH-1:0]      CH_LAST      = CH_WIDTH'(NUM_CH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic [NUM_CH-1:0]         r_pending;
    logic [CH_WIDTH-1:0]       r_ptr;
    logic [CH_WIDTH-1:0]       r_mux_sel;
    logic [SETTLE_WIDTH-1:0]   r_settle_cnt;
    logic [TIMEOUT_WIDTH-1:0]  r_timeout_cnt;

    logic [CH_WIDTH-1:0]       r_rsp_ch;
    logic [DATA_WIDTH-1:0]     r_rsp_data_1;
    logic [DATA_WIDTH-1:0]     r_rsp_data_2;
    logic [DIAP_WIDTH-1:0]     r_rsp_diap;
    logic                      r_rsp_timeout;

    logic [CH_WIDTH-1:0]       w_grant_ch;
    logic [NUM_CH-1:0]         w_clr_mask;
    logic [CH_WIDTH-1:0]       w_ptr_next;
    logic                      w_timed_out;

    // Round-robin search: first pending channel at or above the pointer, wrapping to 0.
    always_comb begin : arbiter
        logic [CH_WIDTH-1:0] v_idx;
        logic                v_found;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        w_grant_ch = r_ptr;
        v_idx      = '0;
        v_found    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_idx = CH_WIDTH'((int'(r_ptr) + k) % NUM_CH);
            if (!v_found && r_pending[v_idx]) begin
                w_grant_ch = v_idx;
                v_found    = 1'b1;
            end
        end
    end

    assign w_clr_mask  = (r_state == ST_DONE) ? (NUM_CH'(1) << r_mux_sel) : '0;
    assign w_ptr_next  = (r_mux_sel == CH_LAST) ? '0 : r_mux_sel + CH_WIDTH'(1);
    assign w_timed_out = (r_timeout_cnt >= TIMEOUT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        conv_start   = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (enable && (r_pending != '0)) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                conv_start   = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (conv_complete || w_timed_out) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: every register is reset asynchronously; a reset must clear outputs before the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending     <= '0;
            r_ptr         <= '0;
            r_mux_sel     <= '0;
            r_settle_cnt  <= '0;
            r_timeout_cnt <= '0;
            r_rsp_ch      <= '0;
            r_rsp_data_1  <= '0;
            r_rsp_data_2  <= '0;
            r_rsp_diap    <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            // A request arriving in the DONE cycle of its own channel survives the clear.
            r_pending <= (r_pending & ~w_clr_mask) | req;

            case (r_state)
                ST_IDLE: begin
                    if (w_state_next == ST_SETTLE) begin
                        r_mux_sel    <= w_grant_ch;
                        r_settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_state_next == ST_START) begin
                        r_timeout_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SETTLE_WIDTH'(1);
                    end
                end
                ST_START: begin
                    r_timeout_cnt <= r_timeout_cnt + TIMEOUT_WIDTH'(1);
                end
                ST_WAIT: begin
                    if (conv_complete) begin
                        r_rsp_ch      <= r_mux_sel;
                        r_rsp_data_1  <= conv_data_1;
                        r_rsp_data_2  <= conv_data_2;
                        r_rsp_diap    <= conv_diap;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_timed_out) begin
                        r_rsp_ch      <= r_mux_sel;
                        r_rsp_data_1  <= '0;
                        r_rsp_data_2  <= '0;
                        r_rsp_diap    <= '0;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    r_ptr <= w_ptr_next;
                end
                default: begin
                end
            endcase
        end
    end

    assign pending      = r_pending;
    assign conv_mux_sel = r_mux_sel;
    assign rsp_ch       = r_rsp_ch;
    assign rsp_data_1   = r_rsp_data_1;
    assign rsp_data_2   = r_rsp_data_2;
    assign rsp_diap     = r_rsp_diap;
    assign rsp_timeout  = r_rsp_timeout;

endmodule
